// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin owner of the vga_adapter pixel port, with a screen-clear sweep.
// Build option: define PLOT_BOUNDS_CHECK_EN to drop granted pixels whose x/y fall off-screen.
module vga_plot_arbiter #(
    parameter int          NUM_REQ      = 3,
    parameter int          X_MAX        = 160,
    parameter int          Y_MAX        = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_x,
    input  logic [7*NUM_REQ-1:0]   req_y,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     ack,
    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   clear_done,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             colour,
    output logic                   plot
);
    localparam int RW  = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CXW = $clog2(X_MAX);
    localparam int CYW = $clog2(Y_MAX);

    // FLUSH holds the last sweep pixel on the bus for one cycle before done is raised
    typedef enum logic [1:0] {ARB, CLEAR, FLUSH} state_e;

    state_e         state_q;
    logic [RW-1:0]  rr_q, rr_d, grant_idx;
    logic [CXW-1:0] cx_q;
    logic [CYW-1:0] cy_q;
    logic [7:0]     x_q, sel_x;
    logic [6:0]     y_q, sel_y;
    logic [2:0]     colour_q, sel_c;
    logic           plot_q, busy_q, done_q;
    logic           grant_valid, accept, in_range, cx_last, cy_last;

    // first pending requester at or above rr, wrapping; the lowest offset wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_q) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = RW'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    assign sel_x   = req_x[8*grant_idx +: 8];
    assign sel_y   = req_y[7*grant_idx +: 7];
    assign sel_c   = req_colour[3*grant_idx +: 3];
    assign accept  = reset_n && state_q == ARB && !clear_start && grant_valid;
    assign rr_d    = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    assign cx_last = cx_q == CXW'(X_MAX - 1);
    assign cy_last = cy_q == CYW'(Y_MAX - 1);
`ifdef PLOT_BOUNDS_CHECK_EN
    assign in_range = int'(sel_x) < X_MAX && int'(sel_y) < Y_MAX;
`else
    assign in_range = 1'b1;
`endif

    // one-hot acknowledge of the requester accepted this cycle
    always_comb begin
        ack            = '0;
        ack[grant_idx] = accept;
    end

    // arbitration / clear-sweep state machine driving the registered plot port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB;
            rr_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ARB: begin
                    if (clear_start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                        plot_q  <= 1'b0;
                    end else if (accept) begin
                        rr_q   <= rr_d;
                        plot_q <= in_range;
                        if (in_range) begin
                            x_q      <= sel_x;
                            y_q      <= sel_y;
                            colour_q <= sel_c;
                        end
                    end else begin
                        plot_q <= 1'b0;
                    end
                end
                CLEAR: begin
                    x_q      <= 8'(cx_q);
                    y_q      <= 7'(cy_q);
                    colour_q <= CLEAR_COLOUR;
                    plot_q   <= 1'b1;
                    if (cx_last) begin
                        cx_q <= '0;
                        if (cy_last) begin
                            cy_q    <= '0;
                            state_q <= FLUSH;
                        end else begin
                            cy_q <= cy_q + 1'b1;
                        end
                    end else begin
                        cx_q <= cx_q + 1'b1;
                    end
                end
                FLUSH: begin
                    plot_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;
endmodule

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Owns the single pixel-write port of the 160x120 vga_adapter (x, y, colour, plot).
- Shares that port between NUM_REQ game requesters: snake datapath, tron player 1 and tron player 2.
- Contains a screen-clear engine that sweeps every pixel to a background colour at game start or reset.
- Sits between the snake/tron datapaths and the VGA instance in the game top level.

Parameters:
- NUM_REQ, 3, number of pixel requesters (index 0..NUM_REQ-1).
- X_MAX, 160, horizontal pixel count; x range 0..X_MAX-1.
- Y_MAX, 120, vertical pixel count; y range 0..Y_MAX-1.
- CLEAR_COLOUR, 3'b000, colour written by the clear sweep.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester pixel request; held until acked.
- req_x  in  8*NUM_REQ  packed x coordinates; requester i uses bits [8i+7:8i].
- req_y  in  7*NUM_REQ  packed y coordinates; requester i uses bits [7i+6:7i].
- req_colour  in  3*NUM_REQ  packed colours; requester i uses bits [3i+2:3i].
- ack  out  NUM_REQ  combinational; high for the granted requester in its acceptance cycle.
- clear_start  in  1  level-sampled request to clear the screen.
- clear_busy  out  1  registered; high while the sweep runs.
- clear_done  out  1  registered; one-cycle pulse after the last clear pixel.
- x  out  8  registered plot x to vga_adapter.
- y  out  7  registered plot y to vga_adapter.
- colour  out  3  registered plot colour.
- plot  out  1  registered write strobe to vga_adapter.

Behaviour:
- Reset (async, reset_n low):
  - x=0, y=0, colour=0, plot=0, clear_busy=0, clear_done=0.
  - Round-robin pointer rr=0; state=ARB; clear counters cx=0, cy=0.
  - ack=0 for as long as reset is asserted.
- Reset asserted mid-sweep aborts immediately. No clear_done is issued. After release the block is in ARB.
- ARB state, evaluated every cycle in this priority order:
  1. clear_start=1: go to CLEAR. No ack this cycle, even if req is set. clear_busy=1 from the next cycle.
  2. Otherwise, if any req bit is set:
     - Grant g = first set bit searching upward from rr, wrapping at NUM_REQ.
     - ack[g]=1 this cycle (combinational); all other ack bits are 0.
     - On the clock edge: x/y/colour load from slice g, plot=1 for one cycle, rr <= (g+1) mod NUM_REQ.
  3. Otherwise: plot=0 next cycle; rr unchanged.
- Latency and throughput: acceptance to plot is 1 cycle; up to one pixel per cycle.
- Requester handshake: after ack, a requester either drops req or presents its next pixel in the following cycle. Back-to-back grants to the same requester occur only when no other requester is pending.
- CLEAR state, one pixel per cycle:
  - Each cycle: x=cx, y=cy, colour=CLEAR_COLOUR, plot=1.
  - cx increments from 0 to X_MAX-1, then wraps to 0 and cy increments.
  - Exactly X_MAX*Y_MAX plot cycles (19200 at defaults), first (0,0), last (159,119).
  - On the edge after the last pixel: clear_busy=0, clear_done=1 for one cycle, cx=cy=0, return to ARB. Pending requests may be granted in that same cycle.
  - During CLEAR: ack=0, requests stay pending, clear_start is ignored.
- Width rules: coordinates pass through unchanged. Counters are sized to hold X_MAX-1 and Y_MAX-1 exactly; no wrap beyond.

Optional Feature:
- Macro: PLOT_BOUNDS_CHECK_EN.
- Defined: a granted pixel with x >= X_MAX or y >= Y_MAX is still acked and still advances rr, but plot stays 0 and x/y/colour hold their previous values. Out-of-range writes are silently dropped.
- Undefined: no range check; every granted pixel is plotted as given.

Test Plan:
- Reset, then req=3'b001 with (x=10, y=20, colour=3'b100) -> ack=3'b001 that cycle; next cycle plot=1, x=10, y=20, colour=4; rr=1.
- req=3'b111 held 3 cycles with rr=0 -> ack sequence 001, 010, 100; plot high 3 consecutive cycles carrying each requester's data in that order.
- clear_start pulse while req=3'b010 -> no ack; 19200 plot cycles from (0,0) to (159,119) with colour=0; clear_busy high throughout; clear_done pulses once; the next cycle after the sweep acks requester 1.
- reset_n low at pixel 5000 of a sweep -> all outputs zero immediately; after release, state is ARB and a new clear_start sweep restarts at (0,0).
- With PLOT_BOUNDS_CHECK_EN: req[0] with x=200, y=5 -> ack=3'b001, plot stays 0, rr=1. Without the macro -> plot=1, x=200.
- clear_start held high across the full sweep -> exactly one sweep during the hold; a second sweep starts in the cycle after clear_done if clear_start is still high.
